// File: rtl/hilo_div_ctrl.sv
`default_nettype none
// ============================================================================
// hilo_div_ctrl : 32-cycle restoring DIV/DIVU controller, one-shot HI/LO write.
// Option HILO_DIV_EARLY_OUT_EN: skip CALC when |divisor| > |dividend|.
// Revision: 1.0
// ============================================================================
module hilo_div_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic        hl_write_enable,
  output logic [63:0] hl_data,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] rem_q, rem_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;
  logic [63:0] hl_q, hl_d;
  logic        dbz_q, dbz_d;

  logic [31:0] w_dvd_mag, w_dvs_mag;
  logic [32:0] w_rem_shift;
  logic        w_rem_ge;
  logic [31:0] w_rem_sub, w_rem_next, w_dvd_next;
  logic [31:0] w_quo_fix, w_rem_fix;
  logic        w_early_out;

  assign w_dvd_mag = (is_signed && dividend[31]) ? (32'd0 - dividend) : dividend;
  assign w_dvs_mag = (is_signed && divisor[31])  ? (32'd0 - divisor)  : divisor;

  // The partial remainder always stays below the divisor (or equals the
  // shifted-in dividend when dividing by zero), so the 32-bit difference is exact.
  assign w_rem_shift = {rem_q, dvd_q[31]};
  assign w_rem_ge    = w_rem_shift >= {1'b0, dvs_q};
  assign w_rem_sub   = w_rem_shift[31:0] - dvs_q;
  assign w_rem_next  = w_rem_ge ? w_rem_sub : w_rem_shift[31:0];
  assign w_dvd_next  = {dvd_q[30:0], w_rem_ge};
  assign w_quo_fix   = q_neg_q ? (32'd0 - w_dvd_next) : w_dvd_next;
  assign w_rem_fix   = r_neg_q ? (32'd0 - w_rem_next) : w_rem_next;

`ifdef HILO_DIV_EARLY_OUT_EN
  assign w_early_out = (w_dvs_mag != 32'd0) && (w_dvs_mag > w_dvd_mag);
`else
  assign w_early_out = 1'b0;
`endif

  always_comb begin
    state_d         = state_q;
    dvd_d           = dvd_q;
    dvs_d           = dvs_q;
    rem_d           = rem_q;
    cnt_d           = cnt_q;
    q_neg_d         = q_neg_q;
    r_neg_d         = r_neg_q;
    hl_d            = hl_q;
    dbz_d           = dbz_q;
    stall           = 1'b0;
    busy            = (state_q != S_IDLE);
    hl_write_enable = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          stall   = 1'b1;
          dvd_d   = w_dvd_mag;
          dvs_d   = w_dvs_mag;
          rem_d   = 32'd0;
          cnt_d   = 5'd0;
          q_neg_d = is_signed & (dividend[31] ^ divisor[31]);
          r_neg_d = is_signed & dividend[31];
          if (w_early_out) begin
            // Quotient is zero and the remainder is the dividend unchanged.
            state_d = S_DONE;
            hl_d    = {dividend, 32'd0};
            dbz_d   = 1'b0;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        stall = 1'b1;
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          rem_d = w_rem_next;
          dvd_d = w_dvd_next;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d = S_DONE;
            hl_d    = {w_rem_fix, w_quo_fix};
            dbz_d   = (dvs_q == 32'd0);
          end
        end
      end
      S_DONE: begin
        hl_write_enable = !flush;
        state_d         = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      dvd_q   <= 32'd0;
      dvs_q   <= 32'd0;
      rem_q   <= 32'd0;
      cnt_q   <= 5'd0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      hl_q    <= 64'd0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      hl_q    <= hl_d;
      dbz_q   <= dbz_d;
    end
  end

  assign hl_data     = hl_q;
  assign div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_hilo_div_ctrl.sv
`default_nettype none
// ============================================================================
// tb_hilo_div_ctrl : directed + random DIV/DIVU sequences against an
// arithmetic reference model. Revision: 1.0
// ============================================================================
module tb_hilo_div_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = 32'd0;
  logic [31:0] divisor = 32'd0;
  logic        flush = 1'b0;
  logic        stall, busy, hl_write_enable, div_by_zero;
  logic [63:0] hl_data;

  int npass = 0;
  int nfail = 0;
  int nchk  = 0;

  hilo_div_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .is_signed       (is_signed),
    .dividend        (dividend),
    .divisor         (divisor),
    .flush           (flush),
    .stall           (stall),
    .busy            (busy),
    .hl_write_enable (hl_write_enable),
    .hl_data         (hl_data),
    .div_by_zero     (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called right after a negedge; the start cycle is the current one.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic noise);
    logic [31:0] am, bm, eq, er;
    logic [63:0] data_obs;
    logic        dbz_obs;
    int          lat, lat_obs;
    am = (s && a[31]) ? (32'd0 - a) : a;
    bm = (s && b[31]) ? (32'd0 - b) : b;
    if (bm == 32'd0) begin
      eq = 32'hFFFF_FFFF;
      er = am;
    end else begin
      eq = am / bm;
      er = am % bm;
    end
    if (s && (a[31] ^ b[31])) eq = 32'd0 - eq;
    if (s && a[31])           er = 32'd0 - er;
    lat = 33;
`ifdef HILO_DIV_EARLY_OUT_EN
    if (bm != 32'd0 && bm > am) lat = 1;
`endif
    start = 1'b1; is_signed = s; dividend = a; divisor = b;
    #1 chk("stall_start", {63'd0, stall}, 64'd1);
    @(posedge clk);
    #1;
    start = 1'b0; dividend = $urandom; divisor = $urandom; is_signed = 1'($urandom);
    lat_obs = 0; data_obs = 64'd0; dbz_obs = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (hl_write_enable) begin
        lat_obs  = k;
        data_obs = hl_data;
        dbz_obs  = div_by_zero;
        start    = 1'b0;
        break;
      end
      chk("stall_calc", {63'd0, stall}, 64'd1);
      if (noise) begin
        start    = 1'($urandom_range(0, 1));
        dividend = $urandom;
        divisor  = $urandom;
      end
    end
    start = 1'b0;
    chk("latency", 64'(lat_obs), 64'(lat));
    chk("hl_data", data_obs, {er, eq});
    chk("div_by_zero", {63'd0, dbz_obs}, {63'd0, (bm == 32'd0)});
    chk("stall_done", {63'd0, stall}, 64'd0);
    chk("busy_done", {63'd0, busy}, 64'd1);
    @(negedge clk);
    chk("strobe_one_cycle", {63'd0, hl_write_enable}, 64'd0);
    chk("busy_idle", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int strobes;
    #3 rst = 1'b0;
    #1;
    chk("rst_stall", {63'd0, stall}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_we", {63'd0, hl_write_enable}, 64'd0);
    chk("rst_data", hl_data, 64'd0);
    chk("rst_dbz", {63'd0, div_by_zero}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Directed cases, issued back-to-back.
    run_div(32'd100, 32'd7, 1'b0, 1'b0);
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_div(32'h1234_5678, 32'd0, 1'b0, 1'b0);
    run_div(32'hFFFF_FFF9, 32'd0, 1'b1, 1'b0);
    run_div(32'd3, 32'd10, 1'b0, 1'b0);
    run_div(32'hFFFF_FFFD, 32'd10, 1'b1, 1'b1);

    // Flush mid-CALC: no strobe, idle next cycle.
    start = 1'b1; is_signed = 1'b0; dividend = 32'd50; divisor = 32'd5;
    @(posedge clk);
    #1 start = 1'b0;
    strobes = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (hl_write_enable) strobes++;
      if (k == 10) flush = 1'b1;
    end
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", {63'd0, busy}, 64'd0);
    chk("flush_stall", {63'd0, stall}, 64'd0);
    chk("flush_no_strobe", 64'(strobes + int'(hl_write_enable)), 64'd0);
    @(negedge clk);
    run_div(32'd50, 32'd5, 1'b0, 1'b0);

    // Asynchronous reset mid-operation.
    start = 1'b1; is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_stall", {63'd0, stall}, 64'd0);
    chk("arst_data", hl_data, 64'd0);
    chk("arst_dbz", {63'd0, div_by_zero}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    strobes = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (hl_write_enable) strobes++;
    end
    chk("arst_no_strobe", 64'(strobes), 64'd0);
    run_div(32'd1000, 32'd3, 1'b0, 1'b0);

    // Random operands with busy-time start noise.
    for (int i = 0; i < 10; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) ra = $urandom_range(0, 15);
      run_div(ra, rb, 1'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
`default_nettype wire
